// File: rtl/star_pkg.sv
// star_pkg: command bit indices, FSM state encodings and command legality check
package star_pkg;
  localparam int CMD_STEP_FWD  = 3;
  localparam int CMD_STEP_BACK = 2;
  localparam int CMD_ACT_FWD   = 1;
  localparam int CMD_ACT_BACK  = 0;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_FAULT} step_st_e;
  typedef enum logic [1:0] {A_OFF, A_FWD, A_BACK, A_DEAD} act_st_e;
  function automatic logic cmd_illegal(input logic [3:0] c);
    return (c[CMD_STEP_FWD] & c[CMD_STEP_BACK]) | (c[CMD_ACT_FWD] & c[CMD_ACT_BACK]) |
           ((c[CMD_STEP_FWD] | c[CMD_STEP_BACK]) & (c[CMD_ACT_FWD] | c[CMD_ACT_BACK]));
  endfunction
endpackage

// File: rtl/star_act_bridge.sv
// star_act_bridge: actuator H-bridge FSM with dead time after every stop
module star_act_bridge
  import star_pkg::*;
#(
  parameter int ACT_DEADTIME = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic fwd,
  input  logic back,
  input  logic kill,
  output logic act_fwd,
  output logic act_back,
  output logic busy
);
  act_st_e st_q, st_d, start;
  logic [31:0] ph_q, ph_d;
  always_comb begin
    start = kill ? A_OFF : (fwd & ~back) ? A_FWD : (back & ~fwd) ? A_BACK : A_OFF;
    st_d = st_q == A_OFF  ? start :
           st_q == A_FWD  ? ((kill | ~fwd)  ? A_DEAD : A_FWD) :
           st_q == A_BACK ? ((kill | ~back) ? A_DEAD : A_BACK) :
           ph_q == ACT_DEADTIME - 1 ? start : A_DEAD;
    ph_d = st_d == st_q ? ph_q + 32'd1 : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q     <= A_OFF;
      ph_q     <= '0;
      act_fwd  <= 1'b0;
      act_back <= 1'b0;
      busy     <= 1'b0;
    end else begin
      st_q     <= st_d;
      ph_q     <= ph_d;
      act_fwd  <= st_d == A_FWD;
      act_back <= st_d == A_BACK;
      busy     <= st_d != A_OFF;
    end
  end
endmodule

// File: rtl/star_motor_driver.sv
// star_motor_driver: stepper pulse generator, actuator drive and fault latch for the star mechanism
module star_motor_driver
  import star_pkg::*;
#(
  parameter int STEP_HIGH    = 50,
  parameter int STEP_PERIOD  = 500,
  parameter int DIR_SETUP    = 100,
  parameter int ACT_DEADTIME = 1000,
  parameter int MAX_STEPS    = 4000,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_cmd,
  output logic             o_step,
  output logic             o_dir,
  output logic             o_step_en,
  output logic             o_act_fwd,
  output logic             o_act_back,
  output logic             o_busy,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_step_cnt
);
  step_st_e st_q, st_d;
  logic [31:0] ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, step_busy_q, act_busy;
  logic ill, st_cmd, lim, last_low, kill;
  always_comb begin
    ill      = cmd_illegal(i_cmd);
    st_cmd   = i_cmd[CMD_STEP_FWD] | i_cmd[CMD_STEP_BACK];
    lim      = st_q == S_LOW && cnt_q >= CNT_W'(MAX_STEPS);
    last_low = st_q == S_LOW && ph_q == STEP_PERIOD - STEP_HIGH - 1;
    st_d = st_q == S_FAULT ? (i_cmd == 4'b0 ? S_IDLE : S_FAULT) :
           (ill | lim)     ? S_FAULT :
           st_q == S_IDLE  ? (st_cmd ? S_SETUP : S_IDLE) :
           st_q == S_SETUP ? (ph_q == DIR_SETUP - 1 ? S_HIGH : S_SETUP) :
           st_q == S_HIGH  ? (ph_q == STEP_HIGH - 1 ? S_LOW : S_HIGH) :
           !last_low ? S_LOW : !st_cmd ? S_IDLE :
           i_cmd[CMD_STEP_FWD] == dir_q ? S_HIGH : S_SETUP;
    ph_d  = st_d == st_q ? ph_q + 32'd1 : '0;
    dir_d = st_d == S_FAULT ? 1'b0 :
            (st_d == S_SETUP && st_q != S_SETUP) ? i_cmd[CMD_STEP_FWD] : dir_q;
    cnt_d = st_d == S_SETUP ? '0 :
            (st_q == S_HIGH && st_d == S_LOW && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    kill  = st_d == S_FAULT;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q        <= S_IDLE;
      ph_q        <= '0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      o_step      <= 1'b0;
      o_step_en   <= 1'b0;
      o_fault     <= 1'b0;
      step_busy_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      ph_q        <= ph_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      o_step      <= st_d == S_HIGH;
      o_step_en   <= st_d inside {S_SETUP, S_HIGH, S_LOW};
      o_fault     <= st_d == S_FAULT;
      step_busy_q <= st_d != S_IDLE;
    end
  end
  star_act_bridge #(.ACT_DEADTIME(ACT_DEADTIME)) u_act (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .fwd     (i_cmd[CMD_ACT_FWD]),
    .back    (i_cmd[CMD_ACT_BACK]),
    .kill    (kill),
    .act_fwd (o_act_fwd),
    .act_back(o_act_back),
    .busy    (act_busy)
  );
  assign o_dir      = dir_q;
  assign o_step_cnt = cnt_q;
  assign o_busy     = step_busy_q | act_busy;
endmodule

// File: tb/tb_star_motor_driver.sv
// tb_star_motor_driver: directed self-checking bench for star_motor_driver
module tb_star_motor_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] cmd = 4'b0;
  logic step, dir, en, fwd, back, busy, fault;
  logic [15:0] cnt;
  int errors = 0, checks = 0;
  star_motor_driver #(
    .STEP_HIGH(2), .STEP_PERIOD(5), .DIR_SETUP(3), .ACT_DEADTIME(4), .MAX_STEPS(6), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .o_step(step), .o_dir(dir), .o_step_en(en),
    .o_act_fwd(fwd), .o_act_back(back), .o_busy(busy), .o_fault(fault), .o_step_cnt(cnt)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [22:0] v(input logic [6:0] f, input int c);
    return {f, 16'(c)};
  endfunction
  task automatic chk(input string tag, input logic [22:0] exp);
    logic [22:0] obs;
    obs = {step, dir, en, fwd, back, busy, fault, cnt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: step/dir/en/fwd/back/busy/fault=%b cnt=%0d, expected %b cnt=%0d",
             tag, obs[22:16], obs[15:0], exp[22:16], exp[15:0]);
    end
  endtask
  initial begin
    tick(2);
    chk("reset", v(7'b0, 0));
    rst = 1'b0;
    cmd = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("t1_c%0d", k), v({(k >= 4 && (k - 4) % 5 < 2), 6'b110010}, k < 6 ? 0 : (k - 6) / 5 + 1));
    end
    cmd = 4'b0100;
    tick();
    chk("t2_low", v(7'b0110010, 4));
    tick(2);
    chk("t2_low_end", v(7'b0110010, 4));
    tick();
    chk("t2_setup", v(7'b0010010, 0));
    tick(2);
    chk("t2_setup_end", v(7'b0010010, 0));
    tick();
    chk("t2_high", v(7'b1010010, 0));
    cmd = 4'b0000;
    tick();
    chk("t2_hold", v(7'b1010010, 0));
    tick();
    chk("t2_low2", v(7'b0010010, 1));
    tick(3);
    chk("t2_idle", v(7'b0, 1));
    cmd = 4'b0010;
    tick();
    chk("t3_fwd", v(7'b0001010, 1));
    tick(4);
    chk("t3_fwd_hold", v(7'b0001010, 1));
    cmd = 4'b0001;
    tick();
    chk("t3_dead0", v(7'b0000010, 1));
    tick(3);
    chk("t3_dead3", v(7'b0000010, 1));
    tick();
    chk("t3_back", v(7'b0000110, 1));
    cmd = 4'b0000;
    tick();
    chk("t3_dead_b", v(7'b0000010, 1));
    tick(3);
    chk("t3_dead_b3", v(7'b0000010, 1));
    tick();
    chk("t3_off", v(7'b0, 1));
    cmd = 4'b1000;
    tick(4);
    chk("t4_high", v(7'b1110010, 0));
    cmd = 4'b1001;
    tick();
    chk("t4_fault", v(7'b0000011, 0));
    cmd = 4'b1000;
    tick();
    chk("t4_latched", v(7'b0000011, 0));
    cmd = 4'b0000;
    tick();
    chk("t4_clear", v(7'b0, 0));
    cmd = 4'b0011;
    tick();
    chk("t4_idle_ill", v(7'b0000011, 0));
    cmd = 4'b0000;
    tick();
    chk("t4_idle_clr", v(7'b0, 0));
    cmd = 4'b0010;
    tick();
    chk("t4_act", v(7'b0001010, 0));
    cmd = 4'b0110;
    tick();
    chk("t4_act_kill", v(7'b0000011, 0));
    cmd = 4'b0000;
    tick();
    chk("t4_dead", v(7'b0000010, 0));
    tick(2);
    chk("t4_dead_end", v(7'b0000010, 0));
    tick();
    chk("t4_off", v(7'b0, 0));
    cmd = 4'b1000;
    tick(31);
    chk("t5_cnt6", v(7'b0110010, 6));
    tick();
    chk("t5_fault", v(7'b0000011, 6));
    cmd = 4'b0000;
    tick();
    chk("t5_idle_hold", v(7'b0, 6));
    cmd = 4'b1000;
    tick(9);
    chk("t6_step", v(7'b1110010, 1));
    rst = 1'b1;
    cmd = 4'b0000;
    tick();
    chk("t6_rst_step", v(7'b0, 0));
    rst = 1'b0;
    cmd = 4'b0010;
    tick();
    chk("t6_act", v(7'b0001010, 0));
    rst = 1'b1;
    tick();
    chk("t6_rst_act", v(7'b0, 0));
    rst = 1'b0;
    cmd = 4'b0000;
    tick();
    chk("t6_nodead", v(7'b0, 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
